exp_decoder_pipe: RTL

- Parametrised, registered binary-to-one-hot/thermometer decoder with valid/ready flow control on both sides.
- A 2-entry skid buffer decouples the upstream and downstream handshakes, so full throughput is kept under backpressure.
- Sits between the index-generating datapath and downstream lane-select/mask logic.
- Successor to the fixed 2-to-4 registered decoder: adds width generalisation, a thermometer mode, range checking and a handshake.

---
 rtl/exp_decoder_pkg.sv | 20 ++
 rtl/exp_decoder_pipe_if.sv | 26 ++
 rtl/exp_decode_core.sv | 28 ++
 rtl/exp_decoder_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/exp_decoder_pkg.sv
// Shared types and constants for the exp_decoder_pipe slice: decode mode, skid occupancy
// states and the widths of the pop statistics counters (built with EXP_DECODER_STATS_EN).
`timescale 1ns/1ps
package exp_decoder_pkg;

  typedef enum logic {
    MODE_ONEHOT = 1'b0,
    MODE_THERM  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam int STAT_CNT_W = 16;
  localparam int STAT_ERR_W = 8;

endpackage

// File: rtl/exp_decoder_pipe_if.sv
// Index-in / word-out handshake bundle of exp_decoder_pipe.
// The master drives indices and consumes words; the slave is the decoder.
`timescale 1ns/1ps
interface exp_decoder_pipe_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 6
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [IN_W-1:0]  num_i;
  logic             mode_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] exp_o;
  logic             err_o;

  modport master (
    output in_valid_i, num_i, mode_i, out_ready_i,
    input  in_ready_o, out_valid_o, exp_o, err_o
  );

  modport slave (
    input  in_valid_i, num_i, mode_i, out_ready_i,
    output in_ready_o, out_valid_o, exp_o, err_o
  );
endinterface

// File: rtl/exp_decode_core.sv
// Combinational index decoder: (num, mode) -> (one-hot or thermometer word, out-of-range flag).
`timescale 1ns/1ps
module exp_decode_core
  import exp_decoder_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 6
) (
  input  logic [IN_W-1:0]  num,
  input  logic             mode,
  output logic [OUT_W-1:0] word,
  output logic             err
);

  // Thermometer bit i is set for any index >= i, so out-of-range indices fill the word with ones.
  always_comb begin
    word = '0;
    err  = (int'(num) >= OUT_W);
    for (int i = 0; i < OUT_W; i++) begin
      if (mode == MODE_THERM) begin
        word[i] = (int'(num) >= i);
      end else begin
        word[i] = (int'(num) == i);
      end
    end
  end

endmodule

// File: rtl/exp_decoder_pipe.sv
// Registered one-hot/thermometer decoder behind a 2-entry skid buffer with valid/ready on both sides.
// Define EXP_DECODER_STATS_EN to add the pop counter cnt_o and the saturating error counter err_cnt_o.
`timescale 1ns/1ps
module exp_decoder_pipe
  import exp_decoder_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int OUT_W = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_n,
  exp_decoder_pipe_if.slave     bus
`ifdef EXP_DECODER_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] cnt_o,
  output logic [STAT_ERR_W-1:0] err_cnt_o
`endif
);

  logic [OUT_W-1:0] dec_word_s;
  logic             dec_err_s;
  occ_e             state_r, state_nxt_s;
  logic [OUT_W-1:0] head_word_r, tail_word_r;
  logic             head_err_r, tail_err_r;
  logic             in_ready_r, out_valid_r;
  logic             in_ready_nxt_s, out_valid_nxt_s;
  logic             accept_s, pop_s;
  logic             head_new_s, head_from_tail_s, tail_load_s;

  exp_decode_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .num  (bus.num_i),
    .mode (bus.mode_i),
    .word (dec_word_s),
    .err  (dec_err_s)
  );

  assign accept_s = bus.in_valid_i & in_ready_r;
  assign pop_s    = out_valid_r & bus.out_ready_i;

  // Occupancy and the registered handshake flags; ready stays low for the whole reset.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Next occupancy plus which skid entry gets loaded from where.
  always_comb begin
    state_nxt_s      = state_r;
    head_new_s       = 1'b0;
    head_from_tail_s = 1'b0;
    tail_load_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          head_new_s  = 1'b1;
          state_nxt_s = ONE;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          head_new_s  = 1'b1;
          state_nxt_s = ONE;
        end else if (accept_s) begin
          tail_load_s = 1'b1;
          state_nxt_s = FULL;
        end else if (pop_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          head_from_tail_s = 1'b1;
          state_nxt_s      = ONE;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // Handshake flags are decoded from the next occupancy and then registered.
  always_comb begin
    in_ready_nxt_s  = 1'b1;
    out_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      EMPTY: begin
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
      end
      ONE: begin
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b1;
      end
      FULL: begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b1;
      end
      default: begin
        in_ready_nxt_s  = 1'b1;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Skid entries; the head keeps its last word when the buffer drains.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      head_word_r <= '0;
      head_err_r  <= 1'b0;
      tail_word_r <= '0;
      tail_err_r  <= 1'b0;
    end else begin
      if (head_new_s) begin
        head_word_r <= dec_word_s;
        head_err_r  <= dec_err_s;
      end else if (head_from_tail_s) begin
        head_word_r <= tail_word_r;
        head_err_r  <= tail_err_r;
      end
      if (tail_load_s) begin
        tail_word_r <= dec_word_s;
        tail_err_r  <= dec_err_s;
      end
    end
  end

  assign bus.in_ready_o  = in_ready_r;
  assign bus.out_valid_o = out_valid_r;
  assign bus.exp_o       = head_word_r;
  assign bus.err_o       = head_err_r;

`ifdef EXP_DECODER_STATS_EN
  localparam logic [STAT_CNT_W-1:0] CNT_INC = STAT_CNT_W'(1);
  localparam logic [STAT_ERR_W-1:0] ERR_INC = STAT_ERR_W'(1);

  logic [STAT_CNT_W-1:0] cnt_r;
  logic [STAT_ERR_W-1:0] err_cnt_r;

  // Pop count wraps; error count sticks at its maximum.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= '0;
      err_cnt_r <= '0;
    end else if (pop_s) begin
      cnt_r <= cnt_r + CNT_INC;
      if (head_err_r && (err_cnt_r != '1)) begin
        err_cnt_r <= err_cnt_r + ERR_INC;
      end
    end
  end

  assign cnt_o     = cnt_r;
  assign err_cnt_o = err_cnt_r;
`endif

endmodule
